// File: rtl/sha256_nonce_sched.sv
// Nonce scan sequencer around one sha256 core; tracks smallest h0.
// Define SCHED_EARLY_EXIT_EN to stop the scan on the first hit.
module sha256_nonce_sched #(
  parameter int NONCE_WORD = 19
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] message_addr,
  input  logic [15:0] output_addr,
  input  logic [31:0] nonce_base,
  input  logic [15:0] num_nonces,
  input  logic [31:0] target,
  output logic        done,
  output logic        found,
  output logic [31:0] best_nonce,
  output logic [31:0] best_h0,
  output logic        error,
  output logic        core_start,
  output logic [15:0] core_message_addr,
  output logic [15:0] core_output_addr,
  input  logic        core_done,
  input  logic        core_mem_we,
  input  logic [15:0] core_mem_addr,
  input  logic [31:0] core_mem_write_data,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WR_NONCE  = 3'd1;
  localparam logic [2:0] LAUNCH    = 3'd2;
  localparam logic [2:0] WAIT_BUSY = 3'd3;
  localparam logic [2:0] WAIT_DONE = 3'd4;
  localparam logic [2:0] RD_ADDR   = 3'd5;
  localparam logic [2:0] RD_DATA   = 3'd6;
  localparam logic [2:0] COMPARE   = 3'd7;

  logic [2:0]  state;
  logic [31:0] nonce;
  logic [31:0] h0;
  logic [31:0] target_q;
  logic [15:0] count;
  logic [15:0] num_q;
  logic [15:0] msg_q;
  logic [15:0] out_q;
  logic [1:0]  wd_cnt;
  logic        hit;
  logic        better;
  logic        last;

  assign hit    = h0 < target_q;
  assign better = h0 < best_h0;
  assign last   = (count + 16'd1) == num_q;

  assign done              = state == IDLE;
  assign mem_clk           = clk;
  assign core_message_addr = msg_q;
  assign core_output_addr  = out_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      nonce      <= '0;
      h0         <= '0;
      target_q   <= '0;
      count      <= '0;
      num_q      <= '0;
      msg_q      <= '0;
      out_q      <= '0;
      wd_cnt     <= '0;
      core_start <= 1'b0;
      found      <= 1'b0;
      best_nonce <= '0;
      best_h0    <= '1;
      error      <= 1'b0;
    end else begin
      core_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            nonce      <= nonce_base;
            count      <= '0;
            num_q      <= num_nonces;
            msg_q      <= message_addr;
            out_q      <= output_addr;
            target_q   <= target;
            found      <= 1'b0;
            best_h0    <= '1;
            best_nonce <= '0;
            error      <= 1'b0;
            if (num_nonces != 16'd0)
              state <= WR_NONCE;
          end
        end
        WR_NONCE: begin
          core_start <= 1'b1;
          state      <= LAUNCH;
        end
        LAUNCH: begin
          wd_cnt <= '0;
          state  <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          // Three busy checks put the error flag 4 cycles after LAUNCH.
          if (!core_done) begin
            state <= WAIT_DONE;
          end else if (wd_cnt == 2'd2) begin
            error <= 1'b1;
            state <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 2'd1;
          end
        end
        WAIT_DONE: begin
          if (core_done)
            state <= RD_ADDR;
        end
        RD_ADDR: state <= RD_DATA;
        RD_DATA: begin
          h0    <= mem_read_data;
          state <= COMPARE;
        end
        COMPARE: begin
          if (better) begin
            best_h0    <= h0;
            best_nonce <= nonce;
          end
          if (hit)
            found <= 1'b1;
          nonce <= nonce + 32'd1;
          count <= count + 16'd1;
`ifdef SCHED_EARLY_EXIT_EN
          // A first hit is always the smallest h0 so far.
          if (last || hit)
            state <= IDLE;
          else
            state <= WR_NONCE;
`else
          if (last)
            state <= IDLE;
          else
            state <= WR_NONCE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    unique case (state)
      WR_NONCE: begin
        mem_we         = 1'b1;
        mem_addr       = msg_q + 16'(NONCE_WORD);
        mem_write_data = nonce;
      end
      WAIT_BUSY, WAIT_DONE: begin
        mem_we         = core_mem_we;
        mem_addr       = core_mem_addr;
        mem_write_data = core_mem_write_data;
      end
      RD_ADDR: mem_addr = out_q;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sha256_nonce_sched.sv
// Bench for sha256_nonce_sched: memory plus behavioural core,
// directed vector table, corner sequences and randomized scans.
module tb_sha256_nonce_sched;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] message_addr;
  logic [15:0] output_addr;
  logic [31:0] nonce_base;
  logic [15:0] num_nonces;
  logic [31:0] target;
  logic        done;
  logic        found;
  logic [31:0] best_nonce;
  logic [31:0] best_h0;
  logic        error;
  logic        core_start;
  logic [15:0] core_message_addr;
  logic [15:0] core_output_addr;
  logic        core_done = 1'b1;
  logic        core_mem_we = 1'b0;
  logic [15:0] core_mem_addr = '0;
  logic [31:0] core_mem_write_data = '0;
  logic        mem_clk;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  always #5 clk = ~clk;

  sha256_nonce_sched dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .message_addr(message_addr),
    .output_addr(output_addr),
    .nonce_base(nonce_base),
    .num_nonces(num_nonces),
    .target(target),
    .done(done),
    .found(found),
    .best_nonce(best_nonce),
    .best_h0(best_h0),
    .error(error),
    .core_start(core_start),
    .core_message_addr(core_message_addr),
    .core_output_addr(core_output_addr),
    .core_done(core_done),
    .core_mem_we(core_mem_we),
    .core_mem_addr(core_mem_addr),
    .core_mem_write_data(core_mem_write_data),
    .mem_clk(mem_clk),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Synchronous memory, one cycle read latency
  logic [31:0] mem [0:65535];
  int we_total = 0;
  int launches = 0;

  always @(posedge mem_clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_write_data;
      we_total <= we_total + 1;
    end
    mem_read_data <= mem[mem_addr];
    if (core_start)
      launches <= launches + 1;
  end

  // Behavioural core: h0 chosen by nonce offset, written to output_addr
  logic [31:0] h_tab [8];
  logic [31:0] cur_base = '0;
  int          cur_lat = 1;
  bit          stuck = 1'b0;
  bit          busy = 1'b0;
  int          left = 0;
  logic [31:0] hreg = '0;

  always @(posedge clk) begin
    core_mem_we <= 1'b0;
    if (stuck) begin
      core_done <= 1'b1;
      busy <= 1'b0;
    end else if (!busy) begin
      if (core_start) begin
        busy <= 1'b1;
        core_done <= 1'b0;
        left <= cur_lat;
        hreg <= h_tab[3'(mem[core_message_addr + 16'd19] - cur_base)];
      end
    end else if (left == 0) begin
      busy <= 1'b0;
      core_done <= 1'b1;
    end else begin
      left <= left - 1;
      if (left == 1) begin
        core_mem_we <= 1'b1;
        core_mem_addr <= core_output_addr;
        core_mem_write_data <= hreg;
      end
    end
  end

  // Reference: scan the h0 list by the rules, no cycle detail
  task automatic model(input logic [31:0] base, input int n,
                       input logic [31:0] tgt, output bit f,
                       output logic [31:0] bn, output logic [31:0] bh,
                       output int tries);
    logic [31:0] h;
    f = 1'b0; bn = '0; bh = '1; tries = 0;
    for (int i = 0; i < n; i++) begin
      h = h_tab[i];
      tries++;
      if (h < bh) begin bh = h; bn = base + 32'(i); end
      if (h < tgt) begin
        f = 1'b1;
`ifdef SCHED_EARLY_EXIT_EN
        break;
`endif
      end
    end
  endtask

  task automatic run_scan(input string nm, input logic [31:0] base,
                          input int n, input logic [31:0] tgt,
                          input int lat, input bit ef,
                          input logic [31:0] ebn, input logic [31:0] ebh,
                          input int tries);
    int cyc;
    int w0;
    @(negedge clk);
    cur_base = base;
    cur_lat = lat;
    message_addr = 16'h0100;
    output_addr = 16'h0200;
    nonce_base = base;
    num_nonces = 16'(n);
    target = tgt;
    start = 1'b1;
    w0 = we_total;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 5000) begin
      cyc++;
      @(negedge clk);
    end
    chk({nm, " done"}, 32'(done), 32'd1);
    chk({nm, " cycles"}, 32'(cyc), 32'(tries * (lat + 7)));
    chk({nm, " found"}, 32'(found), 32'(ef));
    chk({nm, " best_nonce"}, best_nonce, ebn);
    chk({nm, " best_h0"}, best_h0, ebh);
    chk({nm, " error"}, 32'(error), 32'd0);
    chk({nm, " mem_writes"}, 32'(we_total - w0), 32'(2 * tries));
    chk({nm, " nonce_word"}, mem[16'h0113], base + 32'(tries - 1));
  endtask

  typedef struct {
    string       nm;
    logic [31:0] base;
    int          n;
    logic [31:0] tgt;
    int          lat;
    logic [31:0] h [4];
    bit          f;
    logic [31:0] bn;
    logic [31:0] bh;
    int          tries;
  } vec_t;

  vec_t vt [4];

  initial begin
    bit          f;
    logic [31:0] bn;
    logic [31:0] bh;
    logic [31:0] b;
    int          tr;
    int          n;
    int          cyc;

    vt[0] = '{"single", 32'd5, 1, 32'h20, 2,
              '{32'h10, 0, 0, 0}, 1'b1, 32'd5, 32'h10, 1};
    vt[1] = '{"wrap_min", 32'hFFFFFFFE, 4, 32'h0, 1,
              '{32'h50, 32'h30, 32'h30, 32'h40},
              1'b0, 32'hFFFFFFFF, 32'h30, 4};
`ifdef SCHED_EARLY_EXIT_EN
    vt[2] = '{"early", 32'h100, 3, 32'h10, 3,
              '{32'h90, 32'h05, 32'h01, 0},
              1'b1, 32'h101, 32'h05, 2};
`else
    vt[2] = '{"early", 32'h100, 3, 32'h10, 3,
              '{32'h90, 32'h05, 32'h01, 0},
              1'b1, 32'h102, 32'h01, 3};
`endif
    vt[3] = '{"all_max", 32'd7, 3, 32'hFFFFFFFF, 1,
              '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0},
              1'b0, 32'h0, 32'hFFFFFFFF, 3};

    reset_n = 1'b0;
    start = 1'b0;
    message_addr = '0;
    output_addr = '0;
    nonce_base = '0;
    num_nonces = '0;
    target = '0;
    for (int i = 0; i < 8; i++) h_tab[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst done", 32'(done), 32'd1);
    chk("rst core_start", 32'(core_start), 32'd0);
    chk("rst mem_we", 32'(mem_we), 32'd0);
    chk("rst mem_addr", 32'(mem_addr), 32'd0);
    chk("rst mem_wdata", mem_write_data, 32'd0);
    chk("rst found", 32'(found), 32'd0);
    chk("rst best_nonce", best_nonce, 32'd0);
    chk("rst best_h0", best_h0, 32'hFFFFFFFF);
    chk("rst error", 32'(error), 32'd0);
    reset_n = 1'b1;

    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < 4; i++) h_tab[i] = vt[v].h[i];
      run_scan(vt[v].nm, vt[v].base, vt[v].n, vt[v].tgt, vt[v].lat,
               vt[v].f, vt[v].bn, vt[v].bh, vt[v].tries);
    end

    // Zero-length scan right after a scan that left found=1
    h_tab[0] = 32'h3;
    run_scan("pre_zero", 32'd9, 1, 32'h8, 1, 1'b1, 32'd9, 32'h3, 1);
    @(negedge clk);
    num_nonces = 16'd0;
    start = 1'b1;
    tr = we_total;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("zero done", 32'(done), 32'd1);
    chk("zero found", 32'(found), 32'd0);
    chk("zero best_h0", best_h0, 32'hFFFFFFFF);
    chk("zero best_nonce", best_nonce, 32'd0);
    chk("zero mem_we", 32'(we_total - tr), 32'd0);

    // Stuck core: watchdog fires 4 cycles after LAUNCH
    stuck = 1'b1;
    num_nonces = 16'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!core_start && cyc < 20) begin
      cyc++;
      @(negedge clk);
    end
    chk("stuck launch", 32'(core_start), 32'd1);
    repeat (3) @(negedge clk);
    chk("stuck early err", 32'(error), 32'd0);
    @(negedge clk);
    chk("stuck error", 32'(error), 32'd1);
    chk("stuck done", 32'(done), 32'd1);
    repeat (2) @(negedge clk);
    stuck = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during WAIT_DONE of the second nonce
    h_tab[0] = 32'h8; h_tab[1] = 32'h4; h_tab[2] = 32'h2;
    cur_base = 32'h40;
    cur_lat = 6;
    nonce_base = 32'h40;
    num_nonces = 16'd3;
    target = 32'h100;
    tr = launches;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (launches < tr + 2 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    chk("mid launches", 32'(launches - tr), 32'd2);
    repeat (3) @(negedge clk);
    chk("mid best_h0", best_h0, 32'h8);
    reset_n = 1'b0;
    @(negedge clk);
    chk("mid done", 32'(done), 32'd1);
    chk("mid found", 32'(found), 32'd0);
    chk("mid best_h0 rst", best_h0, 32'hFFFFFFFF);
    chk("mid best_nonce", best_nonce, 32'd0);
    chk("mid core_start", 32'(core_start), 32'd0);
    chk("mid mem_we", 32'(mem_we), 32'd0);
    chk("mid mem_addr", 32'(mem_addr), 32'd0);
    reset_n = 1'b1;
    cyc = 0;
    while (!core_done && cyc < 50) begin
      cyc++;
      @(negedge clk);
    end
    chk("mid core idle", 32'(core_done), 32'd1);
    tr = launches;
    repeat (3) @(negedge clk);
    chk("mid no relaunch", 32'(launches - tr), 32'd0);
    model(32'h40, 3, 32'h100, f, bn, bh, tr);
    run_scan("after_rst", 32'h40, 3, 32'h100, 2, f, bn, bh, tr);

    // Randomized scans against the reference
    for (int r = 0; r < 20; r++) begin
      b = $urandom;
      n = $urandom_range(1, 6);
      for (int i = 0; i < 8; i++) h_tab[i] = 32'($urandom_range(0, 80));
      target = 32'($urandom_range(0, 64));
      model(b, n, target, f, bn, bh, tr);
      run_scan($sformatf("rand%0d", r), b, n, target,
               $urandom_range(1, 4), f, bn, bh, tr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sha256_nonce_sched.md
# sha256_nonce_sched

Sequencer that drives one `simplified_sha256` core across a range of nonces for the bitcoin hash flow. For each nonce it patches the message in shared memory, launches the core, waits for completion, and reads back `h0`. It then tracks the best (smallest) `h0` against a target. It owns the single memory port and muxes it between itself and the core.

## Interface
Parameters:
- `NONCE_WORD`, 19: word offset of the nonce inside the 20-word message.

Ports:
- `clk`  in  1  clock; also driven out as `mem_clk`.
- `reset_n`  in  1  synchronous, active-low reset.
- `start`  in  1  begin a scan; sampled only in IDLE.
- `message_addr`  in  16  base address of the 20-word message.
- `output_addr`  in  16  base address of the core's 8-word hash output.
- `nonce_base`  in  32  first nonce.
- `num_nonces`  in  16  number of nonces to try.
- `target`  in  32  hit threshold; hit when `h0 < target` (unsigned).
- `done`  out  1  high in IDLE.
- `found`  out  1  at least one hit in the last scan.
- `best_nonce`  out  32  nonce giving the smallest `h0`.
- `best_h0`  out  32  smallest `h0` seen.
- `error`  out  1  core failed to leave idle after launch.
- `core_start`  out  1  start pulse to the core.
- `core_message_addr`, `core_output_addr`  out  16 each  forwarded address bases.
- `core_done`  in  1  core done (high when the core is idle).
- `core_mem_we`  in  1  core memory request: write enable.
- `core_mem_addr`  in  16  core memory request: address.
- `core_mem_write_data`  in  32  core memory request: write data.
- `mem_clk`  out  1  memory clock.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  16  memory address.
- `mem_write_data`  out  32  memory write data.
- `mem_read_data`  in  32  memory read data; valid the cycle after the address is presented.

## Operation
- States: IDLE, WR_NONCE, LAUNCH, WAIT_BUSY, WAIT_DONE, RD_ADDR, RD_DATA, COMPARE.
- **IDLE, `start` high:**
  - latch all inputs; `nonce` ← `nonce_base`; `count` ← 0.
  - `found` ← 0, `best_h0` ← 32'hFFFFFFFF, `best_nonce` ← 0, `error` ← 0.
  - go to WR_NONCE.
  - if `num_nonces`==0, stay in IDLE with the cleared results.
- **WR_NONCE:** `mem_we`=1, `mem_addr`=`message_addr+NONCE_WORD`, `mem_write_data`=`nonce`; go to LAUNCH.
- **LAUNCH:** `core_start`=1 for exactly this cycle; go to WAIT_BUSY.
- **WAIT_BUSY:**
  - wait for `core_done`==0, then go to WAIT_DONE.
  - watchdog: if `core_done` is still high 4 cycles after LAUNCH, set `error`=1 and go to IDLE.
- **WAIT_DONE:** wait for `core_done`==1 (no timeout); go to RD_ADDR.
- **RD_ADDR:** `mem_we`=0, `mem_addr`=`output_addr`; go to RD_DATA.
- **RD_DATA:** register `mem_read_data` as `h0`; go to COMPARE.
- **COMPARE:**
  - if `h0 < best_h0`, update `best_h0` and `best_nonce`; ties keep the earlier nonce.
  - if `h0 < target`, set `found`=1.
  - `nonce`+1 (wraps modulo 2^32), `count`+1.
  - go to IDLE if `count+1`==`num_nonces`, else WR_NONCE.
- **Memory mux:**
  - WAIT_BUSY and WAIT_DONE: `mem_*` = `core_mem_*`.
  - all other states: scheduler drives; `mem_we`=0 except in WR_NONCE.
- Result outputs hold their values until the next accepted `start`.
- `start` outside IDLE is ignored.

## Timing
- **Reset values:** `done`=1, `core_start`=0, `mem_we`=0, `mem_addr`=0, `mem_write_data`=0, `found`=0, `best_nonce`=0, `best_h0`=32'hFFFFFFFF, `error`=0.
- Reset mid-scan: back to IDLE next edge; the core is not restarted; results read the reset values.
- Per-nonce overhead: 5 scheduler cycles (WR_NONCE, LAUNCH, RD_ADDR, RD_DATA, COMPARE) plus the WAIT_BUSY and WAIT_DONE cycles.
- `done` rises on the cycle after the final COMPARE.
- `core_start` is registered, so the core samples it one cycle after LAUNCH is entered.

## Configuration
- `SCHED_EARLY_EXIT_EN` defined:
  - COMPARE goes to IDLE on the first hit (`h0 < target`).
  - `best_nonce`/`best_h0` report that first hit.
- `SCHED_EARLY_EXIT_EN` undefined: the full range is always scanned and the global minimum is reported.

## Test plan
- **Zero-length scan:** `num_nonces`=0, `start` → `done` stays 1, `found`=0, `best_h0`=FFFFFFFF, no `mem_we` pulse.
- **Single nonce:** `nonce_base`=5, `num_nonces`=1, behavioural core returning h0=0x10, `target`=0x20 → memory word `message_addr+19` = 5, `found`=1, `best_nonce`=5, `best_h0`=0x10.
- **Minimum over range:** 4 nonces from 0xFFFFFFFE with h0 = 0x50, 0x30, 0x30, 0x40, `target`=0 → nonces wrap to 0 and 1, `best_nonce`=0xFFFFFFFF (earlier tie), `best_h0`=0x30, `found`=0.
- **Early exit (`SCHED_EARLY_EXIT_EN`):** h0 = 0x90, 0x05, 0x01, `target`=0x10 → stops after the second nonce with `best_h0`=0x05; without the macro, `best_h0`=0x01 after all three.
- **Stuck core:** `core_done` tied high → `error`=1 exactly 4 cycles after LAUNCH, back to IDLE.
- **Reset mid-scan:** `reset_n` low during WAIT_DONE → next edge all outputs at reset values; a new `start` completes normally.
